sync_mem_ctrl: RTL and testbench

//  Parametrised single-port synchronous data memory; successor to the fixed 32x8 scratch RAM.

---
 rtl/sync_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sync_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_mem_ctrl.sv
// sync_mem_ctrl: single-port synchronous data scratchpad.
// Registered, handshaked read path with latency 1, per-byte write enables,
// a hardware clear sweep (after reset and on demand) and a selectable
// read-during-write return mode for write responses.
module sync_mem_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 5,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // State entered from reset: sweep first, or straight to service.
    localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic       RST_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    // Replace the enabled byte lanes of old_w with the matching lanes of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                m[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return m;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              rst_hold_s;
    logic              accept_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] merged_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    // While reset is held the block already looks busy if a sweep will follow.
    assign rst_hold_s = ~rst_n & RST_BUSY;
    assign req_ready  = (state_q == ST_IDLE) & ~clear & ~rst_hold_s;
    assign accept_s   = req_valid & req_ready;
    assign busy       = (state_q == ST_CLEAR) | rst_hold_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

    assign rd_word_s  = mem[req_addr];
    assign merged_s   = merge_bytes(rd_word_s, req_wdata, req_be);

    // Next-state logic: IDLE serves requests, CLEAR zeroes one word per cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Single write port shared by the clear sweep and accepted writes.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_W{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (!rst_n) begin
            wr_en_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ptr_q;
            wr_data_s = {DATA_W{1'b0}};
        end else if (accept_s && req_we) begin
            wr_en_s   = 1'b1;
            wr_addr_s = req_addr;
            wr_data_s = merged_s;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Response word: reads return the stored word; writes return old or merged word.
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        if (accept_s) begin
            if (req_we && (RDW_MODE != 0)) begin
                rsp_rdata_d = merged_s;
            end else begin
                rsp_rdata_d = rd_word_s;
            end
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // Storage array; intentionally not reset, the sweep provides known contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            ptr_q       <= {ADDR_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= accept_s;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_sync_mem_ctrl.sv
// Testbench for sync_mem_ctrl: two instances (8-bit read-first, 32-bit
// write-first). Stimulus pushes hand-computed responses into per-instance
// queues; negedge monitors pop and compare whenever a response is due.
module tb_sync_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        clear_a, req_valid_a, req_ready_a, req_we_a, rsp_valid_a, busy_a;
    logic [4:0]  req_addr_a;
    logic [7:0]  req_wdata_a, rsp_rdata_a;
    logic [0:0]  req_be_a;

    logic        clear_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, busy_b;
    logic [4:0]  req_addr_b;
    logic [31:0] req_wdata_b, rsp_rdata_b;
    logic [3:0]  req_be_b;

    sync_mem_ctrl #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_be(req_be_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a)
    );

    sync_mem_ctrl #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Cycle counter used to timestamp when each response is due.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance A: valid every cycle, data whenever a response is due.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (q_a.size() > 0) && (q_a[0].due == cyc);
        check("a_rsp_valid", 32'(rsp_valid_a), 32'(exp_v));
        if (exp_v) begin
            check("a_rsp_rdata", 32'(rsp_rdata_a), q_a[0].d);
            void'(q_a.pop_front());
        end else if (q_a.size() > 0 && q_a[0].due < cyc) begin
            void'(q_a.pop_front());
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (q_b.size() > 0) && (q_b[0].due == cyc);
        check("b_rsp_valid", 32'(rsp_valid_b), 32'(exp_v));
        if (exp_v) begin
            check("b_rsp_rdata", rsp_rdata_b, q_b[0].d);
            void'(q_b.pop_front());
        end else if (q_b.size() > 0 && q_b[0].due < cyc) begin
            void'(q_b.pop_front());
        end
    end

    // Issue one request to A (called at posedge+1), expecting response exp.
    task automatic req_a(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                         input logic be, input logic [7:0] exp);
        exp_t e;
        req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr;
        req_wdata_a = wd; req_be_a = be;
        e.d = 32'(exp); e.due = cyc + 1;
        q_a.push_back(e);
        @(posedge clk); #1;
        req_valid_a = 1'b0;
    endtask

    task automatic req_b(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp);
        exp_t e;
        req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr;
        req_wdata_b = wd; req_be_b = be;
        e.d = exp; e.due = cyc + 1;
        q_b.push_back(e);
        @(posedge clk); #1;
        req_valid_b = 1'b0;
    endtask

    // Count consecutive busy cycles of A; optionally pulse clear mid-sweep.
    task automatic count_busy_a(input bit pulse, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            n++;
            if (pulse && i == 5) clear_a = 1'b1;
            if (pulse && i == 6) clear_a = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        clear_a = 1'b0; req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = 5'd0;
        req_wdata_a = 8'h00; req_be_a = 1'b0;
        clear_b = 1'b0; req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 5'd0;
        req_wdata_b = 32'h0; req_be_b = 4'h0;

        // Reset state
        @(negedge clk);
        check("rst_busy_a", 32'(busy_a), 32'd1);
        check("rst_ready_a", 32'(req_ready_a), 32'd0);
        check("rst_rdata_a", 32'(rsp_rdata_a), 32'h0);
        check("rst_rdata_b", rsp_rdata_b, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1: sweep length after reset, then everything reads zero
        count_busy_a(1'b0, n);
        check("t1_busy_cycles", 32'(n), 32'd32);
        check("t1_busy_b_done", 32'(busy_b), 32'd0);
        @(posedge clk); #1;
        check("t1_ready_idle", 32'(req_ready_a), 32'd1);
        for (int i = 0; i < 32; i++) req_a(1'b0, 5'(i), 8'h00, 1'b0, 8'h00);

        // T2: write then read back-to-back
        req_a(1'b1, 5'd3, 8'hA5, 1'b1, 8'h00);
        req_a(1'b0, 5'd3, 8'h00, 1'b0, 8'hA5);

        // T4 (read-first) and be=0 write
        req_a(1'b1, 5'd7, 8'h0F, 1'b1, 8'h00);
        req_a(1'b1, 5'd7, 8'hF0, 1'b1, 8'h0F);
        req_a(1'b0, 5'd7, 8'h00, 1'b0, 8'hF0);
        req_a(1'b1, 5'd7, 8'h55, 1'b0, 8'hF0);
        req_a(1'b0, 5'd7, 8'h00, 1'b0, 8'hF0);
        @(negedge clk);
        check("a_rdata_hold", 32'(rsp_rdata_a), 32'hF0);
        @(posedge clk); #1;

        // T3 byte-enable merge and T4 (write-first) on the 32-bit instance
        req_b(1'b1, 5'd9, 32'h11223344, 4'hF, 32'h11223344);
        req_b(1'b1, 5'd9, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD);
        req_b(1'b0, 5'd9, 32'h0, 4'h0, 32'h11BB33DD);
        req_b(1'b1, 5'd7, 32'h0000000F, 4'h1, 32'h0000000F);
        req_b(1'b1, 5'd7, 32'h000000F0, 4'h1, 32'h000000F0);
        req_b(1'b0, 5'd7, 32'h0, 4'h0, 32'h000000F0);
        req_b(1'b1, 5'd7, 32'hFFFFFFFF, 4'h0, 32'h000000F0);
        @(posedge clk); #1;

        // T5: clear beats a same-cycle read; a mid-sweep clear is ignored
        clear_a = 1'b1; req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 5'd3;
        @(negedge clk);
        check("t5_ready_low", 32'(req_ready_a), 32'd0);
        @(posedge clk); #1;
        clear_a = 1'b0; req_valid_a = 1'b0;
        count_busy_a(1'b1, n);
        check("t5_busy_cycles", 32'(n), 32'd32);
        @(posedge clk); #1;
        req_a(1'b0, 5'd3, 8'h00, 1'b0, 8'h00);
        req_a(1'b0, 5'd7, 8'h00, 1'b0, 8'h00);
        req_a(1'b1, 5'd4, 8'h77, 1'b1, 8'h00);

        // Request coinciding with reset is dropped (no push), then T6
        rst_n = 1'b0; req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 5'd4;
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid_a = 1'b0;
        @(negedge clk);
        check("t6_busy_after_rst", 32'(busy_a), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy_in_rst", 32'(busy_a), 32'd1);
        check("t6_ready_in_rst", 32'(req_ready_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy_a(1'b0, n);
        check("t6_busy_cycles", 32'(n), 32'd32);
        @(posedge clk); #1;
        req_a(1'b0, 5'd4, 8'h00, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
